// File: rtl/bp_fe_bp_pkg.sv
// Shared types and default sizes for the front-end predictor update tracker.
// The entry type depends on the predictor index width, so it is provided as a macro.

// In-flight entry: lookup index plus the prediction returned for it.
`define BP_FE_BP_ENTRY_S(idx_width) struct packed { logic [(idx_width)-1:0] idx; logic pred; }

package bp_fe_bp_pkg;

  localparam int bht_idx_width_default_lp = 10;
  localparam int fifo_els_default_lp      = 8;
  localparam int stat_width_default_lp    = 16;

  // Packed width of one in-flight entry for a given index width.
  function automatic int entry_width(input int idx_width);
    return idx_width + 1;
  endfunction

endpackage

// File: rtl/bp_fe_bp_track_fifo.sv
// In-order circular buffer holding in-flight predictions: push at tail, pop at head,
// synchronous clear of all entries, occupancy count out.

module bp_fe_bp_track_fifo
  import bp_fe_bp_pkg::*;
#(
  parameter int els_p   = fifo_els_default_lp,
  parameter int width_p = entry_width(bht_idx_width_default_lp)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [width_p-1:0]       head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(els_p):0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p) + 1;

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] head_r, tail_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                push_ok, pop_ok;

  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign count_o = count_r;
  assign head_o  = mem_r[head_r];

  // No bypass: a full buffer refuses a push even if a pop happens the same cycle.
  assign push_ok = push_i & ~full_o & ~clear_i;
  assign pop_ok  = pop_i & ~empty_o;

  // NOTE: storage is deliberately not reset; an entry is only read while the count says it is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_r[tail_r] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clear_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (push_ok) tail_r <= tail_r + ptr_w_lp'(1);
      if (pop_ok)  head_r <= head_r + ptr_w_lp'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_bp_update_tracker.sv
// Issues predictor lookups, tracks each prediction in order until its branch resolves,
// then writes the outcome back to the predictor and keeps saturating statistics.

module bp_fe_bp_update_tracker
  import bp_fe_bp_pkg::*;
#(
  parameter int bht_idx_width_p = bht_idx_width_default_lp,
  parameter int fifo_els_p      = fifo_els_default_lp,
  parameter int stat_width_p    = stat_width_default_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         fetch_v_i,
  input  logic [bht_idx_width_p-1:0]   fetch_idx_i,
  output logic                         fetch_ready_o,
  output logic                         predict_taken_o,
  output logic                         r_v_o,
  output logic [bht_idx_width_p-1:0]   idx_r_o,
  input  logic                         predict_i,
  input  logic                         resolve_v_i,
  input  logic                         resolve_taken_i,
  output logic                         resolve_ready_o,
  input  logic                         flush_i,
  output logic                         w_v_o,
  output logic [bht_idx_width_p-1:0]   idx_w_o,
  output logic                         correct_o,
  output logic [$clog2(fifo_els_p):0]  occupancy_o,
  output logic [stat_width_p-1:0]      resolve_cnt_o,
  output logic [stat_width_p-1:0]      mispredict_cnt_o
);

  typedef `BP_FE_BP_ENTRY_S(bht_idx_width_p) entry_s;

  entry_s                  push_entry, head_entry;
  logic                    fifo_full, fifo_empty;
  logic                    pop, mispredict;
  logic [stat_width_p-1:0] resolve_cnt_n, mispredict_cnt_n;

  // Lookup gating: a flush cycle never starts a new lookup.
  assign fetch_ready_o   = ~fifo_full;
  assign r_v_o           = fetch_v_i & fetch_ready_o & ~flush_i;
  assign idx_r_o         = fetch_idx_i;
  assign predict_taken_o = r_v_o & predict_i;

  assign resolve_ready_o = ~fifo_empty;
  assign pop             = resolve_v_i & resolve_ready_o;
  assign push_entry      = '{idx: fetch_idx_i, pred: predict_i};
  assign mispredict      = (head_entry.pred != resolve_taken_i);

  // A resolve in the flush cycle still pops the head before the clear takes effect.
  bp_fe_bp_track_fifo #(
    .els_p   (fifo_els_p),
    .width_p ($bits(entry_s))
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (r_v_o),
    .data_i    (push_entry),
    .pop_i     (pop),
    .clear_i   (flush_i),
    .head_o    (head_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (occupancy_o)
  );

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    resolve_cnt_n    = resolve_cnt_o;
    mispredict_cnt_n = mispredict_cnt_o;
    if (pop && (resolve_cnt_o != '1))
      resolve_cnt_n = resolve_cnt_o + stat_width_p'(1);
    if (pop && mispredict && (mispredict_cnt_o != '1))
      mispredict_cnt_n = mispredict_cnt_o + stat_width_p'(1);
  end

  // Write stage: one cycle behind the accepted resolve; index and verdict hold between writes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o            <= 1'b0;
      idx_w_o          <= '0;
      correct_o        <= 1'b0;
      resolve_cnt_o    <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      w_v_o            <= pop;
      resolve_cnt_o    <= resolve_cnt_n;
      mispredict_cnt_o <= mispredict_cnt_n;
      if (pop) begin
        idx_w_o   <= head_entry.idx;
        correct_o <= ~mispredict;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_tracker.sv
// Randomized and directed bench for the predictor update tracker, checked against a
// queue-based model of the in-flight predictions and saturating statistics.

module tb_bp_fe_bp_update_tracker;

  localparam int idx_w    = 10;
  localparam int els      = 8;
  localparam int stat_w   = 4;
  localparam int stat_max = 15;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              fetch_v_i = 1'b0;
  logic [idx_w-1:0]  fetch_idx_i = '0;
  logic              fetch_ready_o, predict_taken_o, r_v_o;
  logic [idx_w-1:0]  idx_r_o;
  logic              predict_i = 1'b0;
  logic              resolve_v_i = 1'b0;
  logic              resolve_taken_i = 1'b0;
  logic              resolve_ready_o;
  logic              flush_i = 1'b0;
  logic              w_v_o;
  logic [idx_w-1:0]  idx_w_o;
  logic              correct_o;
  logic [3:0]        occupancy_o;
  logic [stat_w-1:0] resolve_cnt_o, mispredict_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bp_update_tracker #(
    .bht_idx_width_p (idx_w),
    .fifo_els_p      (els),
    .stat_width_p    (stat_w)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fetch_v_i        (fetch_v_i),
    .fetch_idx_i      (fetch_idx_i),
    .fetch_ready_o    (fetch_ready_o),
    .predict_taken_o  (predict_taken_o),
    .r_v_o            (r_v_o),
    .idx_r_o          (idx_r_o),
    .predict_i        (predict_i),
    .resolve_v_i      (resolve_v_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_ready_o  (resolve_ready_o),
    .flush_i          (flush_i),
    .w_v_o            (w_v_o),
    .idx_w_o          (idx_w_o),
    .correct_o        (correct_o),
    .occupancy_o      (occupancy_o),
    .resolve_cnt_o    (resolve_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight predictions in program order plus expected write/stat state.
  typedef struct { int idx; bit pred; } ent_t;
  ent_t q[$];
  int   exp_res, exp_mis, exp_idx_w;
  bit   exp_wv, exp_corr;
  bit   exp_ready, exp_rv, exp_pt, exp_rr;
  bit   obs_ready, obs_rv, obs_pt, obs_rr;
  int   obs_idx_r;

  task automatic model_clear();
    q.delete();
    exp_res = 0; exp_mis = 0; exp_idx_w = 0; exp_wv = 0; exp_corr = 0;
  endtask

  // Drive one cycle starting just after a rising edge; sample combinational outputs mid-cycle,
  // advance the model, and return 1 time unit after the next rising edge.
  task automatic step(input bit fv, input int fidx, input bit pr, input bit rv, input bit rt, input bit fl);
    ent_t e;
    fetch_v_i = fv; fetch_idx_i = idx_w'(fidx); predict_i = pr;
    resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
    #2;
    obs_ready = fetch_ready_o; obs_rv = r_v_o; obs_pt = predict_taken_o;
    obs_rr = resolve_ready_o; obs_idx_r = int'(idx_r_o);
    exp_ready = (q.size() < els);
    exp_rv    = fv && exp_ready && !fl;
    exp_pt    = exp_rv && pr;
    exp_rr    = (q.size() > 0);
    exp_wv    = 0;
    if (rv && q.size() > 0) begin
      e = q.pop_front();
      exp_wv = 1; exp_idx_w = e.idx; exp_corr = (e.pred == rt);
      if (exp_res < stat_max) exp_res++;
      if (!exp_corr && exp_mis < stat_max) exp_mis++;
    end
    if (fl) q.delete();
    else if (exp_rv) q.push_back('{fidx, pr});
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    fetch_v_i = 0; predict_i = 0; resolve_v_i = 0; resolve_taken_i = 0; flush_i = 0;
    reset_n_i = 0;
    model_clear();
    #2;
    reset_n_i = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (w_v_o !== 1'b0)        begin errors++; $display("FAIL rst_w_v got=%b exp=0", w_v_o); end
    checks++; if (idx_w_o !== '0)        begin errors++; $display("FAIL rst_idx_w got=%0h exp=0", idx_w_o); end
    checks++; if (correct_o !== 1'b0)    begin errors++; $display("FAIL rst_correct got=%b exp=0", correct_o); end
    checks++; if (occupancy_o !== 4'd0)  begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
    checks++; if (resolve_cnt_o !== '0 || mispredict_cnt_o !== '0)
      begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", resolve_cnt_o, mispredict_cnt_o); end
    checks++; if (fetch_ready_o !== 1'b1 || resolve_ready_o !== 1'b0)
      begin errors++; $display("FAIL rst_ready got=%b/%b exp=1/0", fetch_ready_o, resolve_ready_o); end
    reset_n_i = 1;
    model_clear();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0);
    step(1, 4, 0, 1, 0, 0);
    checks++; if (w_v_o !== 1'b1 || occupancy_o !== 4'd3)
      begin errors++; $display("FAIL mid_pre got w_v=%b occ=%0d exp w_v=1 occ=3", w_v_o, occupancy_o); end
    fetch_v_i = 0; resolve_v_i = 0;
    reset_n_i = 0;
    #1;
    checks++; if (w_v_o !== 1'b0 || idx_w_o !== '0 || correct_o !== 1'b0)
      begin errors++; $display("FAIL mid_rst_write got w_v=%b idx=%0h corr=%b exp 0/0/0", w_v_o, idx_w_o, correct_o); end
    checks++; if (occupancy_o !== 4'd0 || resolve_ready_o !== 1'b0)
      begin errors++; $display("FAIL mid_rst_occ got occ=%0d rr=%b exp 0/0", occupancy_o, resolve_ready_o); end
    checks++; if (resolve_cnt_o !== '0 || mispredict_cnt_o !== '0)
      begin errors++; $display("FAIL mid_rst_stats got=%0d/%0d exp=0/0", resolve_cnt_o, mispredict_cnt_o); end
    #1;
    reset_n_i = 1;
    model_clear();
    @(posedge clk_i); #1;
  endtask

  task automatic test_round_trip();
    do_reset();
    step(1, 5, 1, 0, 0, 0);
    checks++; if (obs_rv !== 1'b1 || obs_idx_r != 5 || obs_pt !== 1'b1)
      begin errors++; $display("FAIL rt_lookup got r_v=%b idx_r=%0h pt=%b exp 1/5/1", obs_rv, obs_idx_r, obs_pt); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (w_v_o !== 1'b1 || idx_w_o !== 10'h005 || correct_o !== 1'b0)
      begin errors++; $display("FAIL rt_write got w_v=%b idx=%0h corr=%b exp 1/5/0", w_v_o, idx_w_o, correct_o); end
    checks++; if (resolve_cnt_o !== 4'd1 || mispredict_cnt_o !== 4'd1)
      begin errors++; $display("FAIL rt_stats got=%0d/%0d exp=1/1", resolve_cnt_o, mispredict_cnt_o); end
    idle();
    checks++; if (w_v_o !== 1'b0 || idx_w_o !== 10'h005 || correct_o !== 1'b0)
      begin errors++; $display("FAIL rt_hold got w_v=%b idx=%0h corr=%b exp 0/5/0", w_v_o, idx_w_o, correct_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) step(1, i, 1'($urandom), 0, 0, 0);
    step(1, 99, 1, 0, 0, 0);
    checks++; if (obs_ready !== 1'b0 || obs_rv !== 1'b0 || obs_pt !== 1'b0)
      begin errors++; $display("FAIL full_gate got rdy=%b r_v=%b pt=%b exp 0/0/0", obs_ready, obs_rv, obs_pt); end
    checks++; if (occupancy_o !== 4'd8)
      begin errors++; $display("FAIL full_occ got=%0d exp=8", occupancy_o); end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 1'($urandom), 0);
      checks++; if (w_v_o !== 1'b1 || idx_w_o !== idx_w'(k) || correct_o !== exp_corr)
        begin errors++; $display("FAIL wrap_pop got w_v=%b idx=%0h corr=%b exp 1/%0h/%b", w_v_o, idx_w_o, correct_o, k, exp_corr); end
    end
    for (int i = 8; i < 11; i++) step(1, i, 1'($urandom), 0, 0, 0);
    checks++; if (occupancy_o !== 4'd8)
      begin errors++; $display("FAIL wrap_occ got=%0d exp=8", occupancy_o); end
    for (int k = 3; k < 11; k++) begin
      step(0, 0, 0, 1, 1'($urandom), 0);
      checks++; if (w_v_o !== 1'b1 || idx_w_o !== idx_w'(k) || correct_o !== exp_corr)
        begin errors++; $display("FAIL wrap_order got w_v=%b idx=%0h corr=%b exp 1/%0h/%b", w_v_o, idx_w_o, correct_o, k, exp_corr); end
    end
    checks++; if (occupancy_o !== 4'd0 || resolve_ready_o !== 1'b0)
      begin errors++; $display("FAIL wrap_empty got occ=%0d rr=%b exp 0/0", occupancy_o, resolve_ready_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 100 + i, 1'($urandom), 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      step(1, 104 + c, 1'($urandom), 1, 1'($urandom), 0);
      checks++; if (occupancy_o !== 4'd4)
        begin errors++; $display("FAIL b2b_occ got=%0d exp=4", occupancy_o); end
      checks++; if (w_v_o !== 1'b1 || idx_w_o !== idx_w'(100 + c) || correct_o !== exp_corr)
        begin errors++; $display("FAIL b2b_write got w_v=%b idx=%0h corr=%b exp 1/%0h/%b", w_v_o, idx_w_o, correct_o, 100 + c, exp_corr); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 200 + i, 1'($urandom), 0, 0, 0);
    step(1, 300, 1, 1, 1, 1);
    checks++; if (obs_rv !== 1'b0 || obs_pt !== 1'b0)
      begin errors++; $display("FAIL flush_lookup got r_v=%b pt=%b exp 0/0", obs_rv, obs_pt); end
    checks++; if (w_v_o !== 1'b1 || idx_w_o !== idx_w'(200) || correct_o !== exp_corr)
      begin errors++; $display("FAIL flush_write got w_v=%b idx=%0h corr=%b exp 1/c8/%b", w_v_o, idx_w_o, correct_o, exp_corr); end
    checks++; if (occupancy_o !== 4'd0 || resolve_ready_o !== 1'b0)
      begin errors++; $display("FAIL flush_drop got occ=%0d rr=%b exp 0/0", occupancy_o, resolve_ready_o); end
    checks++; if (resolve_cnt_o !== 4'(exp_res))
      begin errors++; $display("FAIL flush_stats got=%0d exp=%0d", resolve_cnt_o, exp_res); end
    idle();
    checks++; if (occupancy_o !== 4'd0 || w_v_o !== 1'b0)
      begin errors++; $display("FAIL flush_after got occ=%0d w_v=%b exp 0/0", occupancy_o, w_v_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    step(1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, i, 1, 1, 0, 0);
    checks++; if (resolve_cnt_o !== 4'd15 || mispredict_cnt_o !== 4'd15)
      begin errors++; $display("FAIL sat_hold got=%0d/%0d exp=15/15", resolve_cnt_o, mispredict_cnt_o); end
    step(0, 0, 0, 1, 0, 0);
    checks++; if (idx_w_o !== idx_w'(20) || occupancy_o !== 4'd0)
      begin errors++; $display("FAIL sat_drain got idx=%0h occ=%0d exp 14/0", idx_w_o, occupancy_o); end
    step(0, 0, 0, 1, 1, 0);
    checks++; if (obs_rr !== 1'b0 || w_v_o !== 1'b0)
      begin errors++; $display("FAIL empty_resolve got rr=%b w_v=%b exp 0/0", obs_rr, w_v_o); end
    checks++; if (resolve_cnt_o !== 4'd15 || mispredict_cnt_o !== 4'd15 || idx_w_o !== idx_w'(20))
      begin errors++; $display("FAIL empty_hold got=%0d/%0d idx=%0h exp=15/15/14", resolve_cnt_o, mispredict_cnt_o, idx_w_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)), 1'($urandom),
           $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 31) == 0);
      checks++; if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_pt !== exp_pt || obs_rr !== exp_rr)
        begin errors++; $display("FAIL rnd_comb c=%0d got rdy=%b r_v=%b pt=%b rr=%b exp %b/%b/%b/%b",
          c, obs_ready, obs_rv, obs_pt, obs_rr, exp_ready, exp_rv, exp_pt, exp_rr); end
      checks++; if (w_v_o !== exp_wv || idx_w_o !== idx_w'(exp_idx_w) || correct_o !== exp_corr)
        begin errors++; $display("FAIL rnd_write c=%0d got w_v=%b idx=%0h corr=%b exp %b/%0h/%b",
          c, w_v_o, idx_w_o, correct_o, exp_wv, exp_idx_w, exp_corr); end
      checks++; if (occupancy_o !== 4'(q.size()))
        begin errors++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy_o, q.size()); end
      checks++; if (resolve_cnt_o !== 4'(exp_res) || mispredict_cnt_o !== 4'(exp_mis))
        begin errors++; $display("FAIL rnd_stats c=%0d got=%0d/%0d exp=%0d/%0d", c, resolve_cnt_o, mispredict_cnt_o, exp_res, exp_mis); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_round_trip();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_fe_bp_update_tracker.md
Name: bp_fe_bp_update_tracker

Overview:
Drives the lookup/update interface of the front-end saturating-counter predictors (bimodal, gselect): issues read requests, captures each returned prediction, and holds it in an in-order in-flight FIFO. When the branch resolves, it compares the actual direction with the stored prediction and issues the write (w_v/idx_w/correct) back to the predictor. Sits between fetch/branch-resolution logic and the predictor, and keeps saturating mispredict/resolve statistics.

Parameters:
bht_idx_width_p, 10, width of predictor index; must match the predictor instance
fifo_els_p, 8, in-flight prediction entries; power of 2, >=2
stat_width_p, 16, width of statistics counters

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fetch_v_i  in  1  fetch requests a prediction this cycle
fetch_idx_i  in  bht_idx_width_p  index for the lookup
fetch_ready_o  out  1  tracker can accept a fetch (not full)
predict_taken_o  out  1  prediction returned to fetch (valid with accepted fetch)
r_v_o  out  1  predictor read valid
idx_r_o  out  bht_idx_width_p  predictor read index
predict_i  in  1  predictor output, combinational same cycle
resolve_v_i  in  1  oldest in-flight branch resolved
resolve_taken_i  in  1  actual direction
resolve_ready_o  out  1  an entry is in flight (not empty)
flush_i  in  1  squash all in-flight entries
w_v_o  out  1  predictor write valid
idx_w_o  out  bht_idx_width_p  predictor write index
correct_o  out  1  stored prediction matched actual
occupancy_o  out  $clog2(fifo_els_p)+1  entries in flight
resolve_cnt_o  out  stat_width_p  resolves accepted, saturating
mispredict_cnt_o  out  stat_width_p  incorrect resolves, saturating

Behaviour:
- Reset (async, reset_n_i=0): FIFO empty, pointers 0, occupancy_o=0, w_v_o=0, idx_w_o=0, correct_o=0, both stats 0. Release is synchronous to clk_i through existing flops; no extra sync logic.
- Lookup: r_v_o = fetch_v_i & fetch_ready_o & ~flush_i; idx_r_o = fetch_idx_i (combinational). predict_taken_o = predict_i when r_v_o, else 0.
- Push: on posedge with r_v_o=1, write {fetch_idx_i, predict_i} at tail; tail wraps modulo fifo_els_p.
- fetch_ready_o = (occupancy_o != fifo_els_p). No bypass: when full, a pop in the same cycle does not enable a push.
- Pop: accepted when resolve_v_i & resolve_ready_o. resolve_v_i while empty is ignored: no update, no stat change.
- Update: one-cycle latency. The cycle after an accepted resolve, w_v_o=1, idx_w_o=head idx, correct_o=(head pred == resolve_taken_i). Otherwise w_v_o=0, and idx_w_o/correct_o hold their last value.
- Push and pop in the same cycle: both occur, occupancy unchanged.
- Stats: resolve_cnt_o +1 per accepted resolve; mispredict_cnt_o +1 when correct=0. Both saturate at all-ones and hold. They are not cleared by flush.
- Flush: a resolve accepted in the flush cycle is processed normally (update issued next cycle). All other entries are then dropped: head=tail=0, occupancy_o=0. No push occurs in a flush cycle (r_v_o forced 0).
- No state machine beyond the FIFO plus the registered write stage; the write stage is never back-pressured by the predictor.

Decomposition:
- Shared package bp_fe_bp_pkg: entry struct (idx, pred), parameterised by bht_idx_width_p via macro. Add default constants for fifo_els_p and stat_width_p.
- Sub-module bp_fe_bp_track_fifo: circular buffer with push/pop/clear, occupancy output, async active-low reset.
- Top level contains lookup gating, the compare/write register, and the stat counters.

Test Plan:
- Reset mid-operation: 3 entries in flight, w_v_o=1 -> drop reset_n_i between edges -> all outputs 0 immediately, occupancy_o=0.
- Basic round trip: fetch idx=0x05 with predict_i=1, then resolve taken=0 -> next cycle w_v_o=1, idx_w_o=0x05, correct_o=0, mispredict_cnt_o=1, resolve_cnt_o=1.
- Full/wrap: fifo_els_p=8; push idx 0..7 -> fetch_ready_o=0, r_v_o=0 on 9th fetch. Pop 3, push 3 more (idx 8..10) -> resolves return idx 3..10 in order across pointer wrap.
- Simultaneous push+pop at occupancy 4 for 10 cycles -> occupancy_o stays 4; updates in FIFO order, one per cycle with 1-cycle latency.
- Flush with resolve: 5 in flight; assert flush_i and resolve_v_i together with fetch_v_i=1 -> head entry update issued next cycle, r_v_o=0, occupancy_o=0 afterward, resolve_ready_o=0.
- Saturation/empty: stat_width_p=4; 20 mispredicting resolves -> both counters hold 15. Then resolve_v_i while empty -> w_v_o stays 0 and counters unchanged.
